ldm_stm_seq: RTL and testbench

//  Multi-register transfer sequencer for LDM/STM block transfers. Accepts a 16-bit register

---
 rtl/ldm_stm_seq_pkg.sv | 24 ++
 rtl/ldm_stm_seq_if.sv | 34 +++
 rtl/ldm_stm_seq_lsb_pri_enc.sv | 24 ++
 rtl/ldm_stm_seq.sv | 108 ++++++++++
 tb/tb_ldm_stm_seq.sv | 223 ++++++++++++++++++++++
 5 files changed

// File: rtl/ldm_stm_seq_pkg.sv
// Shared definitions for the LDM/STM multi-register transfer sequencer:
// state encoding, list/word geometry and addressing-mode encodings.
package ldm_stm_seq_pkg;

    localparam int unsigned LIST_W     = 16;
    localparam int unsigned IDX_W      = $clog2(LIST_W);
    localparam int unsigned CNT_W      = $clog2(LIST_W + 1);
    localparam int unsigned WORD_BYTES = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_XFER = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Encoded as {up, pre}.
    typedef enum logic [1:0] {
        MODE_DA = 2'b00,
        MODE_DB = 2'b01,
        MODE_IA = 2'b10,
        MODE_IB = 2'b11
    } mode_e;

endpackage

// File: rtl/ldm_stm_seq_if.sv
// Command and memory-side handshake bundle of the LDM/STM sequencer.
// The slave modport is the sequencer; master is decode plus load/store unit.
interface ldm_stm_seq_if
    import ldm_stm_seq_pkg::*;
#(
    parameter int ADDR_W = 32
);

    logic              start;
    logic [LIST_W-1:0] reg_list;
    logic [ADDR_W-1:0] base_addr;
    logic              up;
    logic              pre;
    logic              mem_ack;

    logic              mem_req;
    logic [IDX_W-1:0]  reg_idx;
    logic [ADDR_W-1:0] mem_addr;
    logic              last;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] wb_addr;

    modport master (
        output start, reg_list, base_addr, up, pre, mem_ack,
        input  mem_req, reg_idx, mem_addr, last, busy, done, wb_addr
    );

    modport slave (
        input  start, reg_list, base_addr, up, pre, mem_ack,
        output mem_req, reg_idx, mem_addr, last, busy, done, wb_addr
    );

endinterface

// File: rtl/ldm_stm_seq_lsb_pri_enc.sv
// Lowest-set-bit encoder: index, any-valid flag and a one-hot mask of that bit,
// used by the dispatcher to pick and then retire the next register.
module lsb_pri_enc
    import ldm_stm_seq_pkg::*;
(
    input  logic [LIST_W-1:0] vec,
    output logic [IDX_W-1:0]  idx,
    output logic              valid,
    output logic [LIST_W-1:0] clr_mask
);

    // NOTE: idx gets a default before the loop so no path leaves it unassigned (no latch).
    always_comb begin
        idx = '0;
        for (int i = LIST_W - 1; i >= 0; i--) begin
            if (vec[i]) idx = IDX_W'(i);
        end
    end

    assign valid    = |vec;
    // Two's-complement trick isolates the lowest set bit.
    assign clr_mask = vec & (~vec + LIST_W'(1));

endmodule

// File: rtl/ldm_stm_seq.sv
// LDM/STM sequencer: latches a register list and base, then issues one
// req/ack-paced word transfer per set bit in ascending register order.
module ldm_stm_seq
    import ldm_stm_seq_pkg::*;
#(
    parameter int ADDR_W = 32
)
(
    input  logic          clk,
    input  logic          rst,
    ldm_stm_seq_if.slave  bus
);

    state_e            state_q, state_d;
    logic [LIST_W-1:0] list_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] wb_q;

    logic [CNT_W-1:0]  n_start;
    logic [ADDR_W-1:0] span;
    logic [ADDR_W-1:0] first_addr;
    logic [ADDR_W-1:0] wb_next;
    logic [IDX_W-1:0]  cur_idx;
    logic              cur_valid;
    logic [LIST_W-1:0] cur_clr;
    logic              xfer_req;
    logic              fire;
    mode_e             mode;

    lsb_pri_enc u_enc (
        .vec      (list_q),
        .idx      (cur_idx),
        .valid    (cur_valid),
        .clr_mask (cur_clr)
    );

    always_comb begin
        n_start = '0;
        for (int i = 0; i < LIST_W; i++) begin
            n_start = n_start + CNT_W'(bus.reg_list[i]);
        end
    end

    assign span = ADDR_W'(n_start) * ADDR_W'(WORD_BYTES);
    assign mode = mode_e'({bus.up, bus.pre});

    // Lowest address of the block; transfers then always walk upward from it.
    always_comb begin
        case (mode)
            MODE_IA: first_addr = bus.base_addr;
            MODE_IB: first_addr = bus.base_addr + ADDR_W'(WORD_BYTES);
            MODE_DA: first_addr = bus.base_addr - span + ADDR_W'(WORD_BYTES);
            default: first_addr = bus.base_addr - span;
        endcase
    end

    assign wb_next  = bus.up ? (bus.base_addr + span) : (bus.base_addr - span);
    assign xfer_req = (state_q == ST_XFER) && cur_valid;
    assign fire     = xfer_req && bus.mem_ack;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) state_d = (bus.reg_list != '0) ? ST_XFER : ST_DONE;
            end
            ST_XFER: begin
                if (fire && (cnt_q == CNT_W'(1))) state_d = ST_DONE;
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            list_q <= '0;
            cnt_q  <= '0;
            addr_q <= '0;
            wb_q   <= '0;
        end else if ((state_q == ST_IDLE) && bus.start) begin
            list_q <= bus.reg_list;
            cnt_q  <= n_start;
            addr_q <= first_addr;
            wb_q   <= wb_next;
        end else if (fire) begin
            list_q <= list_q & ~cur_clr;
            cnt_q  <= cnt_q - CNT_W'(1);
            addr_q <= addr_q + ADDR_W'(WORD_BYTES);
        end
    end

    assign bus.mem_req  = xfer_req;
    assign bus.reg_idx  = cur_idx;
    assign bus.mem_addr = addr_q;
    assign bus.last     = (state_q == ST_XFER) && (cnt_q == CNT_W'(1));
    assign bus.busy     = (state_q != ST_IDLE);
    assign bus.done     = (state_q == ST_DONE);
    assign bus.wb_addr  = wb_q;

endmodule

// File: tb/tb_ldm_stm_seq.sv
// Scoreboard bench for ldm_stm_seq: expected transfers and writeback values are
// queued at launch and compared as the sequencer presents them.
module tb_ldm_stm_seq;

    typedef struct {
        logic [3:0]  idx;
        logic [31:0] addr;
        logic        last;
    } xfer_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    ldm_stm_seq_if #(.ADDR_W(32)) bus ();

    ldm_stm_seq #(.ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    xfer_t       xq[$];
    logic [31:0] wq[$];
    int          compared   = 0;
    int          mismatched = 0;
    int          ack_seen   = 0;
    int          done_seen  = 0;
    int          ack_mode   = 0;
    int          cyc        = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Ack pattern: 0 always, 1 every third cycle, 2 random.
    initial begin
        bus.mem_ack = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            case (ack_mode)
                0:       bus.mem_ack = 1'b1;
                1:       bus.mem_ack = ((cyc % 3) == 0);
                default: bus.mem_ack = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: every requesting cycle must match the scoreboard head, which also proves hold-while-stalled.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.mem_req) begin
                if (xq.size() == 0) begin
                    check("unexpected_req", 1, 0);
                end else begin
                    check("reg_idx", 64'(bus.reg_idx), 64'(xq[0].idx));
                    check("mem_addr", 64'(bus.mem_addr), 64'(xq[0].addr));
                    check("last", 64'(bus.last), 64'(xq[0].last));
                    if (bus.mem_ack) begin
                        void'(xq.pop_front());
                        ack_seen++;
                    end
                end
            end
            if (bus.done) begin
                check("req_during_done", 64'(bus.mem_req), 0);
                if (wq.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    check("wb_addr", 64'(bus.wb_addr), 64'(wq.pop_front()));
                end
                done_seen++;
            end
        end
    end

    task automatic launch(input logic [15:0] list, input logic [31:0] base,
                          input logic up, input logic pre, input logic [31:0] exp_wb);
        int          n;
        int          k;
        logic [31:0] lowest;
        xfer_t       e;
        n = $countones(list);
        if (up) lowest = pre ? base + 32'd4 : base;
        else    lowest = pre ? base - 32'(4 * n) : base - 32'(4 * n) + 32'd4;
        k = 0;
        for (int i = 0; i < 16; i++) begin
            if (list[i]) begin
                e.idx  = 4'(i);
                e.addr = lowest + 32'(4 * k);
                e.last = (k == n - 1);
                xq.push_back(e);
                k++;
            end
        end
        wq.push_back(exp_wb);
        @(posedge clk);
        #1;
        bus.start     = 1'b1;
        bus.reg_list  = list;
        bus.base_addr = base;
        bus.up        = up;
        bus.pre       = pre;
        @(posedge clk);
        #1;
        bus.start     = 1'b0;
        bus.reg_list  = $urandom();
        bus.base_addr = $urandom();
        @(negedge clk);
        check("first_req_latency", 64'(bus.mem_req), 64'(list != 16'h0));
        check("empty_done_latency", 64'(bus.done), 64'(list == 16'h0));
        check("busy_after_start", 64'(bus.busy), 1);
    endtask

    task automatic wait_done(input string tag, input int base_cnt);
        int budget;
        budget = 400;
        while ((done_seen == base_cnt) && (budget > 0)) begin
            @(posedge clk);
            budget--;
        end
        check({tag, "_done_timeout"}, 64'(budget == 0), 0);
        @(negedge clk);
        check({tag, "_idle_busy"}, 64'(bus.busy), 0);
        check({tag, "_idle_done"}, 64'(bus.done), 0);
        check({tag, "_xq_drained"}, 64'(xq.size()), 0);
        check({tag, "_wq_drained"}, 64'(wq.size()), 0);
    endtask

    initial begin
        int d0;
        int a0;
        int budget;
        bus.start     = 1'b0;
        bus.reg_list  = '0;
        bus.base_addr = '0;
        bus.up        = 1'b0;
        bus.pre       = 1'b0;

        #23;
        check("rst_mem_req", 64'(bus.mem_req), 0);
        check("rst_busy", 64'(bus.busy), 0);
        check("rst_done", 64'(bus.done), 0);
        check("rst_last", 64'(bus.last), 0);
        check("rst_reg_idx", 64'(bus.reg_idx), 0);
        check("rst_mem_addr", 64'(bus.mem_addr), 0);
        check("rst_wb_addr", 64'(bus.wb_addr), 0);
        rst = 1'b0;

        ack_mode = 0; d0 = done_seen;
        launch(16'h000F, 32'h0000_1000, 1'b1, 1'b0, 32'h0000_1010);
        wait_done("ia_000f", d0);

        ack_mode = 1; d0 = done_seen;
        launch(16'h8001, 32'h0000_2000, 1'b0, 1'b1, 32'h0000_1FF8);
        wait_done("db_8001", d0);

        ack_mode = 0; d0 = done_seen;
        launch(16'h0000, 32'h0000_0040, 1'b1, 1'b1, 32'h0000_0040);
        wait_done("ib_empty", d0);

        ack_mode = 0; d0 = done_seen;
        launch(16'hFFFF, 32'hFFFF_FFF0, 1'b1, 1'b0, 32'h0000_0030);
        wait_done("ia_wrap", d0);

        ack_mode = 2; d0 = done_seen;
        launch(16'h1234, 32'h0000_0103, 1'b1, 1'b1, 32'h0000_0117);
        wait_done("ib_lowbits", d0);

        // Reset in the middle of an 8-register block.
        ack_mode = 0; a0 = ack_seen;
        launch(16'h00FF, 32'h0000_3000, 1'b1, 1'b0, 32'h0000_3020);
        budget = 50;
        while ((ack_seen < a0 + 2) && (budget > 0)) begin
            @(posedge clk);
            budget--;
        end
        check("rst_wait_timeout", 64'(budget == 0), 0);
        #3;
        rst = 1'b1;
        #1;
        check("midrst_mem_req", 64'(bus.mem_req), 0);
        check("midrst_busy", 64'(bus.busy), 0);
        check("midrst_done", 64'(bus.done), 0);
        xq.delete();
        wq.delete();
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;

        ack_mode = 2; d0 = done_seen;
        launch(16'h00FF, 32'h0000_6000, 1'b1, 1'b0, 32'h0000_6020);
        wait_done("post_rst", d0);

        // A second start while busy must not disturb the running block.
        ack_mode = 1; d0 = done_seen;
        launch(16'h0A50, 32'h0000_5000, 1'b0, 1'b0, 32'h0000_4FF0);
        bus.start    = 1'b1;
        bus.reg_list = 16'hFFFF;
        bus.up       = 1'b1;
        @(posedge clk);
        #1;
        bus.start    = 1'b0;
        wait_done("busy_start", d0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
